divergence_resume_unit: RTL and testbench
=========================================

Name: divergence_resume_unit

Overview:
- Consumer/reader side of the divergence queue.
- When the active thread path finishes, this block does four things:
  - drains the pipeline;
  - pops the next saved thread context (regs, PC, exec mask) from the queue head;
  - restores that context to the core through a valid/ready handshake;
  - signals all_done once the queue is empty at a path end.
- Sits between the branch/retire stage (path_done), the divergence queue (pop side) and the fetch/register-file restore path.

Parameters:
- ADDR_WIDTH, 64, width of memory_address_t (PC).
- MASK_WIDTH, 8, width of execution_mask_t (one bit per lane).
- REGS_WIDTH, 512, flattened width of the RegisterFile packed struct.
- COUNT_WIDTH, 16, width of the resume counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: begin executing the initial path
- path_done  input  1  one-cycle pulse: current path reached its reconvergence point or halted
- pipeline_idle  input  1  no instructions of the current path remain in flight
- q_empty  input  1  queue is_empty()
- q_regs  input  REGS_WIDTH  queue head regs (get_back)
- q_pc  input  ADDR_WIDTH  queue head PC
- q_mask  input  MASK_WIDTH  queue head exec mask
- q_pop  output  1  one-cycle pulse: advance_read_pos
- stall_fetch  output  1  fetch must not issue
- restore_valid  output  1  restore bundle valid
- restore_ready  input  1  core accepts restore bundle
- restore_regs  output  REGS_WIDTH  restored register file
- restore_pc  output  ADDR_WIDTH  restored PC
- restore_mask  output  MASK_WIDTH  restored exec mask
- all_done  output  1  every path has completed
- resume_count  output  COUNT_WIDTH  number of contexts restored
- err_sticky  output  1  protocol error seen

Behaviour:
- States: IDLE, RUN, DRAIN, LOAD, RESTORE, DONE.
- Reset (any state, including mid-RESTORE):
  - state goes to IDLE;
  - q_pop=0, restore_valid=0, restore_* data=0, all_done=0, resume_count=0, err_sticky=0, stall_fetch=1;
  - no pop is issued in the reset cycle.
- IDLE: stall_fetch=1. On start, go to RUN.
- RUN: stall_fetch=0. On path_done, go to DRAIN.
- DRAIN: stall_fetch=1. When pipeline_idle=1:
  - if q_empty=1, go to DONE;
  - otherwise latch q_regs/q_pc/q_mask into the output registers and go to LOAD.
  - Head data is sampled only in this cycle.
- LOAD: q_pop=1 for exactly this one cycle, then go to RESTORE.
- RESTORE: restore_valid=1 with the latched data.
  - Data must stay stable while restore_valid=1 and restore_ready=0.
  - On restore_valid&&restore_ready:
    - increment resume_count, saturating at all ones;
    - restore_valid drops the next cycle;
    - go to RUN.
  - restore_ready may already be high on entry: the handshake then completes in the first RESTORE cycle.
- DONE: all_done=1 and stall_fetch=1. On start, clear all_done and go to RUN; resume_count is kept.
- Minimum latency, with pipeline_idle and restore_ready both high:
  - path_done at cycle T;
  - DRAIN at T+1, LOAD/q_pop at T+2;
  - restore_valid at T+3, RUN at T+4.
- Protocol errors set err_sticky, which is cleared only by reset:
  - path_done in any state other than RUN (the pulse is otherwise ignored);
  - start outside IDLE/DONE (ignored).
- q_pop is never asserted while q_empty=1.
- path_done and start together in RUN: path_done wins; start flags an error.

Optional Feature:
- Macro: DIVERGENCE_SKIP_EMPTY_MASK_EN.
- Defined: in LOAD, if the latched mask is all zeros, q_pop is still asserted but the context is discarded:
  - go back to DRAIN instead of RESTORE;
  - resume_count is not incremented;
  - DRAIN then re-evaluates q_empty on the next cycle.
- Undefined: zero-mask contexts are restored like any other.

Test Plan:
- Reset, start, path_done with q_empty=1, pipeline_idle=1 -> DONE 2 cycles after path_done; all_done=1; q_pop never asserted; resume_count=0.
- Queue holds one entry (PC=0x1000, mask=0x0F); path_done with idle/ready high -> q_pop single pulse at T+2; restore_valid at T+3 with pc=0x1000, mask=0x0F; resume_count=1; stall_fetch=0 at T+4.
- Same entry, restore_ready held low for 5 cycles -> restore_valid and data stable for all 5 cycles; exactly one q_pop; accepted on the 6th cycle.
- pipeline_idle low for 10 cycles after path_done -> no q_pop and stall_fetch=1 throughout; LOAD follows the first idle cycle.
- Assert reset during RESTORE -> next cycle restore_valid=0, q_pop=0, resume_count=0, IDLE; path_done in IDLE -> err_sticky=1.
- With DIVERGENCE_SKIP_EMPTY_MASK_EN: queue holds mask=0x00 then mask=0x30 -> two q_pop pulses, one restore with mask=0x30, resume_count=1.

Source files
------------

// File: rtl/divergence_resume_unit.sv
// Reader side of the divergence queue: drains the pipeline at a path end, pops the
// saved context and restores it via valid/ready. Optional macro: DIVERGENCE_SKIP_EMPTY_MASK_EN.
module divergence_resume_unit #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned MASK_WIDTH  = 8,
  parameter int unsigned REGS_WIDTH  = 512,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   path_done,
  input  logic                   pipeline_idle,
  input  logic                   q_empty,
  input  logic [REGS_WIDTH-1:0]  q_regs,
  input  logic [ADDR_WIDTH-1:0]  q_pc,
  input  logic [MASK_WIDTH-1:0]  q_mask,
  output logic                   q_pop,
  output logic                   stall_fetch,
  output logic                   restore_valid,
  input  logic                   restore_ready,
  output logic [REGS_WIDTH-1:0]  restore_regs,
  output logic [ADDR_WIDTH-1:0]  restore_pc,
  output logic [MASK_WIDTH-1:0]  restore_mask,
  output logic                   all_done,
  output logic [COUNT_WIDTH-1:0] resume_count,
  output logic                   err_sticky
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_LOAD, S_RESTORE, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [REGS_WIDTH-1:0]  regs_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [MASK_WIDTH-1:0]  mask_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d;
  logic                   latch_head;
  logic                   accept;

  always_comb begin
    state_d    = state_q;
    latch_head = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (path_done) state_d = S_DRAIN;
      S_DRAIN: begin
        if (pipeline_idle) begin
          if (q_empty) begin
            state_d = S_DONE;
          end else begin
            latch_head = 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
`ifdef DIVERGENCE_SKIP_EMPTY_MASK_EN
        // Zero-lane contexts are popped and dropped; DRAIN re-checks the queue.
        state_d = (mask_q == '0) ? S_DRAIN : S_RESTORE;
`else
        state_d = S_RESTORE;
`endif
      end
      S_RESTORE: begin
        if (restore_ready) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (path_done && state_q != S_RUN) err_d = 1'b1;
    if (start && state_q != S_IDLE && state_q != S_DONE) err_d = 1'b1;
    count_d = count_q;
    if (accept && count_q != '1) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      regs_q  <= '0;
      pc_q    <= '0;
      mask_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (latch_head) begin
        regs_q <= q_regs;
        pc_q   <= q_pc;
        mask_q <= q_mask;
      end
    end
  end

  assign q_pop         = (state_q == S_LOAD) && !q_empty;
  assign stall_fetch   = (state_q != S_RUN);
  assign restore_valid = (state_q == S_RESTORE);
  assign all_done      = (state_q == S_DONE);
  assign restore_regs  = regs_q;
  assign restore_pc    = pc_q;
  assign restore_mask  = mask_q;
  assign resume_count  = count_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_divergence_resume_unit.sv
// Directed bench for divergence_resume_unit; inputs change and outputs are sampled 1ns after posedge.
module tb_divergence_resume_unit;

  logic         clk = 1'b0;
  logic         reset, start, path_done, pipeline_idle, q_empty;
  logic [511:0] q_regs;
  logic [63:0]  q_pc;
  logic [7:0]   q_mask;
  logic         q_pop, stall_fetch, restore_valid, restore_ready;
  logic [511:0] restore_regs;
  logic [63:0]  restore_pc;
  logic [7:0]   restore_mask;
  logic         all_done;
  logic [15:0]  resume_count;
  logic         err_sticky;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [511:0] regs_a;

  divergence_resume_unit #(
    .ADDR_WIDTH(64), .MASK_WIDTH(8), .REGS_WIDTH(512), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .path_done(path_done),
    .pipeline_idle(pipeline_idle), .q_empty(q_empty), .q_regs(q_regs),
    .q_pc(q_pc), .q_mask(q_mask), .q_pop(q_pop), .stall_fetch(stall_fetch),
    .restore_valid(restore_valid), .restore_ready(restore_ready),
    .restore_regs(restore_regs), .restore_pc(restore_pc),
    .restore_mask(restore_mask), .all_done(all_done),
    .resume_count(resume_count), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (q_pop === 1'b1) pops++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; path_done = 1'b0; pipeline_idle = 1'b1;
    q_empty = 1'b1; q_regs = '0; q_pc = '0; q_mask = '0; restore_ready = 1'b1;
    regs_a = {16{32'hA5A5_0001}};
    #1;
    tick(); tick();
    reset = 1'b0;
    pops = 0;
    chk("rst_stall", stall_fetch, 1);
    chk("rst_pop", q_pop, 0);
    chk("rst_valid", restore_valid, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_count", resume_count, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_pc", restore_pc, 0);

    // start -> RUN
    start = 1'b1; tick(); start = 1'b0;
    chk("run_stall", stall_fetch, 0);

    // Empty queue at path end -> DONE two cycles later
    path_done = 1'b1; tick(); path_done = 1'b0;
    chk("A_drain_stall", stall_fetch, 1);
    chk("A_drain_done", all_done, 0);
    tick();
    chk("A_all_done", all_done, 1);
    chk("A_stall", stall_fetch, 1);
    chk("A_pops", pops, 0);
    chk("A_count", resume_count, 0);
    chk("A_err", err_sticky, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("A_restart_done", all_done, 0);
    chk("A_restart_stall", stall_fetch, 0);

    // One entry, minimum latency
    q_empty = 1'b0; q_pc = 64'h1000; q_mask = 8'h0F; q_regs = regs_a; pops = 0;
    path_done = 1'b1; tick(); path_done = 1'b0;
    chk("B_T1_pop", q_pop, 0);
    chk("B_T1_stall", stall_fetch, 1);
    tick();
    chk("B_T2_pop", q_pop, 1);
    tick();
    q_empty = 1'b1;
    chk("B_T3_valid", restore_valid, 1);
    chk("B_T3_pop", q_pop, 0);
    chk("B_T3_pc", restore_pc, 64'h1000);
    chk("B_T3_mask", restore_mask, 8'h0F);
    chk("B_T3_regs", restore_regs, regs_a);
    tick();
    chk("B_T4_stall", stall_fetch, 0);
    chk("B_T4_valid", restore_valid, 0);
    chk("B_count", resume_count, 1);
    chk("B_pops", pops, 1);

    // Backpressure: ready low for 5 RESTORE cycles
    q_empty = 1'b0; q_pc = 64'h2000; q_mask = 8'h3C; restore_ready = 1'b0; pops = 0;
    path_done = 1'b1; tick(); path_done = 1'b0;
    tick();
    chk("C_pop", q_pop, 1);
    tick();
    q_empty = 1'b1; q_pc = 64'hDEAD; q_mask = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      chk("C_hold_valid", restore_valid, 1);
      chk("C_hold_pc", restore_pc, 64'h2000);
      chk("C_hold_mask", restore_mask, 8'h3C);
      tick();
    end
    restore_ready = 1'b1;
    chk("C_6th_valid", restore_valid, 1);
    chk("C_6th_count", resume_count, 1);
    tick();
    chk("C_after_valid", restore_valid, 0);
    chk("C_count", resume_count, 2);
    chk("C_pops", pops, 1);

    // Pipeline busy for 10 cycles after path end
    pipeline_idle = 1'b0; q_empty = 1'b0; q_pc = 64'h3000; q_mask = 8'h01; pops = 0;
    path_done = 1'b1; tick(); path_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("D_busy_pop", q_pop, 0);
      chk("D_busy_stall", stall_fetch, 1);
      tick();
    end
    pipeline_idle = 1'b1;
    chk("D_busy_pops", pops, 0);
    tick();
    chk("D_load_pop", q_pop, 1);
    tick();
    q_empty = 1'b1;
    chk("D_pc", restore_pc, 64'h3000);
    tick();
    chk("D_count", resume_count, 3);

    // path_done and start together in RUN: path_done wins, start is an error
    path_done = 1'b1; start = 1'b1; tick(); path_done = 1'b0; start = 1'b0;
    chk("F_drain_stall", stall_fetch, 1);
    chk("F_err", err_sticky, 1);
    tick();
    chk("F_done", all_done, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("F_kept_count", resume_count, 3);

    // Reset mid-RESTORE
    q_empty = 1'b0; q_pc = 64'h4000; q_mask = 8'h02; restore_ready = 1'b0;
    path_done = 1'b1; tick(); path_done = 1'b0;
    tick(); tick();
    chk("E_valid_pre", restore_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("E_valid", restore_valid, 0);
    chk("E_pop", q_pop, 0);
    chk("E_count", resume_count, 0);
    chk("E_stall", stall_fetch, 1);
    chk("E_pc", restore_pc, 0);
    chk("E_err", err_sticky, 0);
    q_empty = 1'b1; restore_ready = 1'b1;
    path_done = 1'b1; tick(); path_done = 1'b0;
    chk("E_idle_pd_err", err_sticky, 1);
    chk("E_idle_stall", stall_fetch, 1);

    // Zero-mask head followed by mask 0x30
    start = 1'b1; tick(); start = 1'b0;
    q_empty = 1'b0; q_pc = 64'h5000; q_mask = 8'h00; pops = 0;
    path_done = 1'b1; tick(); path_done = 1'b0;
    tick();
    chk("G_pop1", q_pop, 1);
`ifdef DIVERGENCE_SKIP_EMPTY_MASK_EN
    tick();
    q_pc = 64'h6000; q_mask = 8'h30;
    chk("G_skip_valid", restore_valid, 0);
    chk("G_skip_stall", stall_fetch, 1);
    tick();
    chk("G_pop2", q_pop, 1);
    tick();
    q_empty = 1'b1;
    chk("G_valid", restore_valid, 1);
    chk("G_mask", restore_mask, 8'h30);
    chk("G_pc", restore_pc, 64'h6000);
    tick();
    chk("G_count", resume_count, 1);
`else
    tick();
    q_pc = 64'h6000; q_mask = 8'h30;
    chk("G_zero_valid", restore_valid, 1);
    chk("G_zero_mask", restore_mask, 8'h00);
    chk("G_zero_pc", restore_pc, 64'h5000);
    tick();
    chk("G_count1", resume_count, 1);
    path_done = 1'b1; tick(); path_done = 1'b0;
    tick();
    chk("G_pop2", q_pop, 1);
    tick();
    q_empty = 1'b1;
    chk("G_mask", restore_mask, 8'h30);
    tick();
    chk("G_count", resume_count, 2);
`endif
    chk("G_pops", pops, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
